// File: rtl/terminal_request_arbiter_if.sv
// Command offer handshake between the terminal request arbiter (master) and the
// output-routing stage (slave).
interface terminal_request_arbiter_if;
  logic       req_valid;
  logic       req_ack;
  logic       req_term;
  logic [2:0] req_code;
  logic [2:0] req_auth;

  modport master (
    output req_valid,
    output req_term,
    output req_code,
    output req_auth,
    input  req_ack
  );

  modport slave (
    input  req_valid,
    input  req_term,
    input  req_code,
    input  req_auth,
    output req_ack
  );
endinterface

// File: rtl/terminal_request_arbiter.sv
// Two-terminal request front end: sync, debounce, command latching, round-robin offer with hold.
// Define ARB_TIMEOUT_EN to add a 256-cycle OFFER watchdog that drops unacknowledged requests.
module terminal_request_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 1024
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [3:0]                        hh0,
  input  logic [1:0]                        b0,
  input  logic [3:0]                        hh1,
  input  logic [1:0]                        b1,
  terminal_request_arbiter_if.master        req,
  output logic                              busy,
  output logic                              err
);
  localparam int unsigned      CntW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned      HoldW  = $clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0]  CntMax = CntW'(DEBOUNCE_CYCLES);
  localparam logic [HoldW-1:0] HoldLd = HoldW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StOffer, StHold} state_e;

  logic [1:0][3:0]      hh_meta_q, hh_sync_q;
  logic [1:0][1:0]      b_meta_q, b_sync_q, b_prev_q;
  logic [1:0][1:0]      b_db_q, b_db_d;
  logic [1:0][CntW-1:0] cnt_q, cnt_d;
  logic [1:0][2:0]      slot_code_q, slot_code_d, slot_auth_q, slot_auth_d;
  logic [1:0][2:0]      held_code_q, held_code_d, held_auth_q, held_auth_d;
  logic [1:0]           held_v_q, held_v_d, pend_q, pend_d;
  logic [1:0]           ev, reject, frozen;
  logic [1:0][2:0]      ev_code, ev_auth;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic             sel, grant, fin, timeout;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             req_valid_q, req_valid_d, req_term_q, req_term_d;
  logic [2:0]       req_code_q, req_code_d, req_auth_q, req_auth_d;
  logic             busy_q, busy_d, err_q, err_d;
`ifdef ARB_TIMEOUT_EN
  logic [7:0]       wd_q, wd_d;
`endif

  // Debounce: count consecutive identical synchronized samples; an event is 00 -> nonzero.
  always_comb begin
    cnt_d   = cnt_q;
    b_db_d  = b_db_q;
    ev      = '0;
    ev_code = '0;
    ev_auth = '0;
    for (int t = 0; t < 2; t++) begin
      if (b_sync_q[t] != b_prev_q[t]) begin
        cnt_d[t] = CntW'(1);
      end else if (cnt_q[t] < CntMax) begin
        cnt_d[t] = cnt_q[t] + 1'b1;
      end
      if (cnt_d[t] == CntMax) b_db_d[t] = b_sync_q[t];
      ev[t]      = (b_db_q[t] == 2'b00) && (b_db_d[t] != 2'b00);
      ev_code[t] = {hh_sync_q[t][3], b_db_d[t]};
      ev_auth[t] = hh_sync_q[t][2:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    hold_d      = hold_q;
    req_valid_d = req_valid_q;
    req_term_d  = req_term_q;
    req_code_d  = req_code_q;
    req_auth_d  = req_auth_q;
    grant       = 1'b0;
    fin         = 1'b0;
    timeout     = 1'b0;
    sel         = (pend_q[0] & pend_q[1]) ? rr_q : pend_q[1];
`ifdef ARB_TIMEOUT_EN
    wd_d        = wd_q;
`endif
    case (state_q)
      StIdle: begin
        if (|pend_q) begin
          grant       = 1'b1;
          req_valid_d = 1'b1;
          req_term_d  = sel;
          req_code_d  = slot_code_q[sel];
          req_auth_d  = slot_auth_q[sel];
          state_d     = StOffer;
`ifdef ARB_TIMEOUT_EN
          wd_d        = '0;
`endif
        end
      end
      StOffer: begin
        if (req.req_ack) begin
          fin         = 1'b1;
          rr_d        = ~req_term_q;
          req_valid_d = 1'b0;
          hold_d      = HoldLd;
          state_d     = StHold;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wd_q == 8'hff) begin
          fin         = 1'b1;
          timeout     = 1'b1;
          rr_d        = ~req_term_q;
          req_valid_d = 1'b0;
          state_d     = StIdle;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      StHold: begin
        if (hold_q == '0) state_d = StIdle;
        else              hold_d  = hold_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // A slot is frozen from the grant edge until the edge that ends its offer; events for a frozen
  // slot park in the held buffer and are loaded when the offer finishes.
  always_comb begin
    slot_code_d = slot_code_q;
    slot_auth_d = slot_auth_q;
    held_code_d = held_code_q;
    held_auth_d = held_auth_q;
    held_v_d    = held_v_q;
    pend_d      = pend_q;
    reject      = '0;
    frozen      = '0;
    for (int t = 0; t < 2; t++) begin
      frozen[t] = ((state_q == StOffer) && (req_term_q == t[0]) && !fin) ||
                  (grant && (sel == t[0]));
      if (fin && (req_term_q == t[0])) begin
        pend_d[t] = held_v_q[t];
        if (held_v_q[t]) begin
          slot_code_d[t] = held_code_q[t];
          slot_auth_d[t] = held_auth_q[t];
        end
        held_v_d[t] = 1'b0;
      end
      if (ev[t]) begin
        if (ev_auth[t] == 3'b000) begin
          reject[t] = 1'b1;
        end else if (frozen[t]) begin
          held_code_d[t] = ev_code[t];
          held_auth_d[t] = ev_auth[t];
          held_v_d[t]    = 1'b1;
        end else begin
          slot_code_d[t] = ev_code[t];
          slot_auth_d[t] = ev_auth[t];
          pend_d[t]      = 1'b1;
        end
      end
    end
    err_d = (|reject) | timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hh_meta_q   <= '0;
      hh_sync_q   <= '0;
      b_meta_q    <= '0;
      b_sync_q    <= '0;
      b_prev_q    <= '0;
      b_db_q      <= '0;
      cnt_q       <= '0;
      slot_code_q <= '0;
      slot_auth_q <= '0;
      held_code_q <= '0;
      held_auth_q <= '0;
      held_v_q    <= '0;
      pend_q      <= '0;
      state_q     <= StIdle;
      rr_q        <= 1'b0;
      hold_q      <= '0;
      req_valid_q <= 1'b0;
      req_term_q  <= 1'b0;
      req_code_q  <= '0;
      req_auth_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      hh_meta_q   <= {hh1, hh0};
      hh_sync_q   <= hh_meta_q;
      b_meta_q    <= {b1, b0};
      b_sync_q    <= b_meta_q;
      b_prev_q    <= b_sync_q;
      b_db_q      <= b_db_d;
      cnt_q       <= cnt_d;
      slot_code_q <= slot_code_d;
      slot_auth_q <= slot_auth_d;
      held_code_q <= held_code_d;
      held_auth_q <= held_auth_d;
      held_v_q    <= held_v_d;
      pend_q      <= pend_d;
      state_q     <= state_d;
      rr_q        <= rr_d;
      hold_q      <= hold_d;
      req_valid_q <= req_valid_d;
      req_term_q  <= req_term_d;
      req_code_q  <= req_code_d;
      req_auth_q  <= req_auth_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
`ifdef ARB_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

  assign req.req_valid = req_valid_q;
  assign req.req_term  = req_term_q;
  assign req.req_code  = req_code_q;
  assign req.req_auth  = req_auth_q;
  assign busy          = busy_q;
  assign err           = err_q;
endmodule

// File: tb/tb_terminal_request_arbiter.sv
// Scoreboard bench for terminal_request_arbiter: directed presses push expected offers, a
// monitor pops and compares on each rising req_valid.
module tb_terminal_request_arbiter;
  localparam int unsigned Deb  = 4;
  localparam int unsigned Hold = 8;

  typedef struct packed {
    logic       term;
    logic [2:0] code;
    logic [2:0] auth;
  } item_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] hh0   = '0;
  logic [3:0] hh1   = '0;
  logic [1:0] b0    = '0;
  logic [1:0] b1    = '0;
  logic       busy, err;

  item_t exp_q[$];
  item_t cur;
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_offers = 0;

  terminal_request_arbiter_if bus ();

  terminal_request_arbiter #(
    .DEBOUNCE_CYCLES (Deb),
    .HOLD_CYCLES     (Hold)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hh0   (hh0),
    .b0    (b0),
    .hh1   (hh1),
    .b1    (b1),
    .req   (bus),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  function automatic item_t mk(input logic term, input logic [2:0] code, input logic [2:0] auth);
    return {term, code, auth};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int cyc);
    cyc = 0;
    while (!bus.req_valid && cyc < max) begin
      tick(1);
      cyc++;
    end
    if (!bus.req_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_valid: req_valid still 0 after %0d cycles, required 1", max);
    end
  endtask

  task automatic wait_idle(input int max);
    int c;
    c = 0;
    while (busy && c < max) begin
      tick(1);
      c++;
    end
    if (busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", max);
    end
  endtask

  task automatic ack();
    bus.req_ack = 1'b1;
    tick(1);
    bus.req_ack = 1'b0;
  endtask

  // Monitor: compare each new offer against the scoreboard and re-check it on the ack cycle.
  initial begin
    logic  seen;
    item_t got;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      got = {bus.req_term, bus.req_code, bus.req_auth};
      if (bus.req_valid && !seen) begin
        n_offers++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_offer: got %0h, required no offer", got);
        end else begin
          cur = exp_q.pop_front();
          check("offer", int'(got), int'(cur));
        end
      end else if (bus.req_valid && bus.req_ack) begin
        check("offer_stable_at_ack", int'(got), int'(cur));
      end
      seen = bus.req_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cyc, base, errs, err_at, lowc;
    logic busy_seen, val_seen;
    bus.req_ack = 1'b0;

    // Reset
    #2 rst_n = 1'b0;
    #1 check("reset_outputs", int'({bus.req_valid, bus.req_term, bus.req_code, bus.req_auth,
                                     busy, err}), 0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // 1: reset mid-OFFER, then a clean request
    hh0 = 4'b1011;
    b0  = 2'b01;
    exp_q.push_back(mk(1'b0, 3'b101, 3'b011));
    wait_valid(30, cyc);
    check("s1_latency", cyc, 7);
    check("s1_busy", int'(busy), 1);
    tick(3);
    rst_n = 1'b0;
    #1 check("s1_reset_mid_offer", int'({bus.req_valid, bus.req_term, bus.req_code,
                                          bus.req_auth, busy, err}), 0);
    b0  = 2'b00;
    hh0 = 4'b0000;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    hh0 = 4'b1011;
    b0  = 2'b01;
    exp_q.push_back(mk(1'b0, 3'b101, 3'b011));
    wait_valid(30, cyc);
    check("s1_latency_after_reset", cyc, 7);
    ack();
    check("s1_valid_drop", int'(bus.req_valid), 0);
    b0 = 2'b00;
    wait_idle(40);
    tick(10);

    // 2: bounce yields exactly one event
    hh1 = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      b1 = 2'b10;
      tick(2);
      b1 = 2'b00;
      tick(2);
    end
    base = n_offers;
    b1 = 2'b10;
    exp_q.push_back(mk(1'b1, 3'b010, 3'b110));
    wait_valid(30, cyc);
    check("s2_latency", cyc, 7);
    ack();
    wait_idle(40);
    tick(20);
    check("s2_single_event", n_offers - base, 1);
    b1 = 2'b00;
    tick(10);

    // 3: contention and round robin
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    hh0 = 4'b1001;
    hh1 = 4'b0111;
    b0  = 2'b10;
    b1  = 2'b01;
    exp_q.push_back(mk(1'b0, 3'b110, 3'b001));
    exp_q.push_back(mk(1'b1, 3'b001, 3'b111));
    wait_valid(30, cyc);
    check("s3_first_term", int'(bus.req_term), 0);
    ack();
    check("s3_hold_valid_low", int'(bus.req_valid), 0);
    check("s3_hold_term_kept", int'(bus.req_term), 0);
    check("s3_hold_busy", int'(busy), 1);
    wait_valid(30, cyc);
    check("s3_hold_gap", cyc, 9);
    check("s3_second_term", int'(bus.req_term), 1);
    b0 = 2'b00;
    b1 = 2'b00;
    tick(8);
    ack();
    wait_idle(40);
    tick(2);
    b0 = 2'b10;
    b1 = 2'b01;
    exp_q.push_back(mk(1'b0, 3'b110, 3'b001));
    exp_q.push_back(mk(1'b1, 3'b001, 3'b111));
    wait_valid(30, cyc);
    check("s3_repeat_term", int'(bus.req_term), 0);
    ack();
    wait_valid(30, cyc);
    ack();
    b0 = 2'b00;
    b1 = 2'b00;
    wait_idle(40);
    tick(10);

    // 4: bad authentication
    hh1 = 4'b1000;
    b1  = 2'b11;
    errs      = 0;
    busy_seen = 1'b0;
    val_seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (err) errs++;
      busy_seen |= busy;
      val_seen  |= bus.req_valid;
    end
    check("s4_err_pulses", errs, 1);
    check("s4_no_busy", int'(busy_seen), 0);
    check("s4_no_valid", int'(val_seen), 0);
    b1 = 2'b00;
    tick(10);

    // 5: overwrite while pending, freeze while on offer
    hh0 = 4'b0001;
    b0  = 2'b01;
    exp_q.push_back(mk(1'b0, 3'b001, 3'b001));
    wait_valid(30, cyc);
    hh1 = 4'b0101;
    b1  = 2'b01;
    tick(8);
    b1 = 2'b00;
    tick(8);
    hh1 = 4'b0011;
    b1  = 2'b10;
    tick(8);
    exp_q.push_back(mk(1'b1, 3'b010, 3'b011));
    b0 = 2'b00;
    ack();
    wait_valid(30, cyc);
    b1 = 2'b00;
    tick(8);
    hh1 = 4'b1110;
    b1  = 2'b11;
    tick(8);
    check("s5_frozen_code", int'(bus.req_code), 2);
    exp_q.push_back(mk(1'b1, 3'b111, 3'b110));
    ack();
    wait_valid(30, cyc);
    ack();
    b1 = 2'b00;
    wait_idle(40);
    tick(10);

    // 6: long OFFER without ack
    hh0 = 4'b1111;
    b0  = 2'b11;
    exp_q.push_back(mk(1'b0, 3'b111, 3'b111));
    wait_valid(30, cyc);
`ifdef ARB_TIMEOUT_EN
    err_at = -1;
    for (int i = 1; i <= 300; i++) begin
      tick(1);
      if (err && err_at < 0) err_at = i;
    end
    check("s6_timeout_err_cycle", err_at, 256);
    check("s6_idle_after_timeout", int'({bus.req_valid, busy}), 0);
`else
    lowc = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (!bus.req_valid) lowc++;
    end
    check("s6_valid_held", lowc, 0);
    check("s6_busy_held", int'(busy), 1);
    ack();
`endif
    b0 = 2'b00;
    wait_idle(40);
    tick(5);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
